// File: rtl/arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter
// and the selector it drives.
package arbiter_pkg;

  typedef logic [3:0] data_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_t;

  localparam int DATA_W = $bits(data_t);

  // Widest supported grant counter; narrower counters saturate at a low slice of this.
  localparam int          CNT_W_LIMIT = 32;
  localparam logic [31:0] CNT_MAX     = '1;

endpackage

// File: rtl/selector2_4.sv
// Two-input, 4-bit data selector: y follows d1 when s is high, else d0.
module selector2_4 (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic       s,
  output logic [3:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/arbiter2_4.sv
// Round-robin arbiter for two valid/ready requesters, steering the winner
// through selector2_4 into a single-entry output register with grant counters.
module arbiter2_4
  import arbiter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit RESET_PRIO = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  if (WIDTH != DATA_W) begin : g_width_check
    $error("arbiter2_4: WIDTH must be 4 to match selector2_4");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_LIMIT) begin : g_cnt_check
    $error("arbiter2_4: CNT_W out of range");
  end

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_MAX[CNT_W-1:0];

  logic  prio;
  src_t  grant;
  logic  load;
  logic  any_valid;
  data_t sel_y;

  // Handshake: a word transfers on a clock edge where valid and ready are both
  // high. Ready may look at valid combinationally; valid never looks at ready.
  // The output register accepts when empty or being drained in the same cycle.
  assign load      = !out_valid || out_ready;
  assign any_valid = req0_valid || req1_valid;

  always_comb begin
    grant = src_t'(prio);
    if (req0_valid && !req1_valid) grant = SRC0;
    else if (req1_valid && !req0_valid) grant = SRC1;
  end

  assign sel        = grant;
  assign req0_ready = !reset && load && req0_valid && (grant == SRC0);
  assign req1_ready = !reset && load && req1_valid && (grant == SRC1);

  selector2_4 u_selector (
    .d0 (req0_data),
    .d1 (req1_data),
    .s  (sel),
    .y  (sel_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      prio      <= RESET_PRIO;
      cnt0      <= '0;
      cnt1      <= '0;
    end else if (load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_y;
        out_src   <= grant;
        prio      <= ~grant;
        // Counters stick at all-ones so fairness ratios are never corrupted by wrap.
        if (grant == SRC0 && cnt0 != CNT_TOP) cnt0 <= cnt0 + 1'b1;
        if (grant == SRC1 && cnt1 != CNT_TOP) cnt1 <= cnt1 + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbiter2_4.sv
// Directed bench for arbiter2_4: a default instance plus a CNT_W=2,
// RESET_PRIO=1 instance sharing the same stimulus.
module tb_arbiter2_4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, out_ready;
  logic [3:0] req0_data, req1_data;

  logic       req0_ready, req1_ready, sel, out_valid, out_src;
  logic [3:0] out_data;
  logic [7:0] cnt0, cnt1;

  logic       s_req0_ready, s_req1_ready, s_sel, s_out_valid, s_out_src;
  logic [3:0] s_out_data;
  logic [1:0] s_cnt0, s_cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_w;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  arbiter2_4 #(.WIDTH(4), .RESET_PRIO(1'b0), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  arbiter2_4 #(.WIDTH(4), .RESET_PRIO(1'b1), .CNT_W(2)) dut_s (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (s_req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (s_req1_ready),
    .sel        (s_sel),
    .out_valid  (s_out_valid),
    .out_data   (s_out_data),
    .out_src    (s_out_src),
    .out_ready  (out_ready),
    .cnt0       (s_cnt0),
    .cnt1       (s_cnt1)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [3:0] d0,
                       input logic v1, input logic [3:0] d1,
                       input logic ordy);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pops the scoreboard and compares against the word just registered.
  task automatic check_word(input string tag, input logic [3:0] src_exp);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp_w = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, {28'd0, out_data}, {28'd0, exp_w});
      check({tag, "_src"}, {31'd0, out_src}, {31'd0, src_exp});
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 4'h0, 1'b1, 4'h0, 1'b1);

    // Reset then idle.
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    tick();
    check("rst_ready0_b", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1_b", {31'd0, req1_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cnt0", {24'd0, cnt0}, 32'd0);
    check("rst_cnt1", {24'd0, cnt1}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    tick();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_sel", {31'd0, sel}, 32'd0);
    check("idle_sel_prio1", {31'd0, s_sel}, 32'd1);

    // Contention: alternating grants starting with requester 0.
    drive(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
    check("cont_ready0", {31'd0, req0_ready}, 32'd1);
    check("cont_ready1", {31'd0, req1_ready}, 32'd0);
    exp_q.push_back(4'h3);
    exp_q.push_back(4'hC);
    exp_q.push_back(4'h3);
    exp_q.push_back(4'hC);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_word("cont", i[0]);
    end
    check("cont_cnt0", {24'd0, cnt0}, 32'd2);
    check("cont_cnt1", {24'd0, cnt1}, 32'd2);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_hold_data", {28'd0, out_data}, 32'hC);
    check("drain_hold_src", {31'd0, out_src}, 32'd1);
    check("drain_sel", {31'd0, sel}, 32'd0);

    // Single source on requester 1, full rate.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 4'h0, 1'b1, i[3:0], 1'b1);
      check("single_ready1", {31'd0, req1_ready}, 32'd1);
      check("single_ready0", {31'd0, req0_ready}, 32'd0);
      check("single_sel", {31'd0, sel}, 32'd1);
      exp_q.push_back(i[3:0]);
      tick();
      check_word("single", 1'b1);
    end
    check("single_cnt1", {24'd0, cnt1}, 32'd5);
    check("single_sat_cnt1", {30'd0, s_cnt1}, 32'd3);

    // Backpressure: load A, then stall three cycles with both requesting.
    drive(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
    exp_q.push_back(4'hA);
    tick();
    check_word("bp_load", 1'b0);
    drive(1'b1, 4'h5, 1'b1, 4'h6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready0", {31'd0, req0_ready}, 32'd0);
      check("bp_ready1", {31'd0, req1_ready}, 32'd0);
      check("bp_prio_sel", {31'd0, sel}, 32'd1);
      tick();
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {28'd0, out_data}, 32'hA);
    end
    drive(1'b1, 4'h5, 1'b1, 4'h6, 1'b1);
    check("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
    exp_q.push_back(4'h6);
    tick();
    check_word("bp_nobubble", 1'b1);
    check("bp_cnt0", {24'd0, cnt0}, 32'd3);
    check("bp_cnt1", {24'd0, cnt1}, 32'd6);

    // Saturation: fresh reset, requester 0 alone five times.
    reset = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, 4'h0, 1'b1);
      exp_q.push_back(req0_data);
      tick();
      check_word("sat", 1'b0);
      check("sat_cnt0_w2", {30'd0, s_cnt0}, (i < 3) ? i : 3);
      check("sat_cnt0_w8", {24'd0, cnt0}, i);
    end

    // Reset during a stall discards the held word and restores priority.
    drive(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
    exp_q.push_back(4'h7);
    tick();
    check_word("mid_load", 1'b0);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    tick();
    check("mid_stall_data", {28'd0, out_data}, 32'h7);
    reset = 1'b1;
    drive(1'b1, 4'h9, 1'b1, 4'h9, 1'b1);
    check("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {28'd0, out_data}, 32'd0);
    check("mid_rst_src", {31'd0, out_src}, 32'd0);
    check("mid_rst_cnt0", {24'd0, cnt0}, 32'd0);
    check("mid_rst_cnt1", {24'd0, cnt1}, 32'd0);
    check("mid_rst_prio", {31'd0, sel}, 32'd0);
    check("mid_rst_prio_s", {31'd0, s_sel}, 32'd1);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
